pe_elastic_switch_matrix: RTL and testbench

//  Parametrised, elastic successor of the PE tile switch matrix. It routes NUM_IN

---
 rtl/pe_elastic_switch_matrix_if.sv | 28 ++
 rtl/pe_elastic_switch_matrix.sv | 132 +++++++++++++
 tb/tb_pe_elastic_switch_matrix.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pe_elastic_switch_matrix_if.sv
// Handshake bundle for the elastic switch matrix: NUM_IN source channels in,
// NUM_OUT FIFO-backed destination channels out, plus per-output occupancy.
interface pe_elastic_switch_matrix_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_IN  = 9,
  parameter int NUM_OUT = 7,
  parameter int DEPTH   = 2
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [NUM_IN*WIDTH-1:0]  in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*LVL_W-1:0] out_level;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_level
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_level
  );
endinterface

// File: rtl/pe_elastic_switch_matrix.sv
// Elastic PE tile switch matrix: config-selected routing of NUM_IN handshaked inputs
// into per-output DEPTH-entry FIFOs, with lazy (atomic) fan-out to all selecting outputs.
module pe_elastic_switch_matrix #(
  parameter  int WIDTH        = 32,
  parameter  int NUM_IN       = 9,
  parameter  int NUM_OUT      = 7,
  parameter  int DEPTH        = 2,
  localparam int SEL_W        = $clog2(NUM_IN + 1),
  localparam int NoConfigBits = NUM_OUT * SEL_W
) (
  input  logic                    UserCLK,
  input  logic                    RESET_N,
  input  logic [NoConfigBits-1:0] ConfigBits,
  pe_elastic_switch_matrix_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [NUM_OUT][DEPTH];
  logic [WIDTH-1:0] mem_d [NUM_OUT][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_OUT];
  logic [PTR_W-1:0] wr_ptr_d [NUM_OUT];
  logic [PTR_W-1:0] rd_ptr_q [NUM_OUT];
  logic [PTR_W-1:0] rd_ptr_d [NUM_OUT];
  logic [LVL_W-1:0] level_q  [NUM_OUT];
  logic [LVL_W-1:0] level_d  [NUM_OUT];

  logic [SEL_W-1:0] sel_s       [NUM_OUT];
  logic [WIDTH-1:0] push_data_s [NUM_OUT];
  logic [NUM_OUT-1:0] space_s;
  logic [NUM_OUT-1:0] valid_s;
  logic [NUM_OUT-1:0] push_s;
  logic [NUM_OUT-1:0] pop_s;
  logic [NUM_IN-1:0]  ready_s;
  logic [NUM_IN-1:0]  fire_s;

  // Ready is built from FIFO space only (no push-through), so it never sees out_ready.
  always_comb begin
    ready_s = '1;
    push_s  = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      sel_s[j]       = ConfigBits[j*SEL_W +: SEL_W];
      space_s[j]     = (level_q[j] != FULL_LVL);
      valid_s[j]     = (level_q[j] != '0);
      pop_s[j]       = valid_s[j] & bus.out_ready[j];
      push_data_s[j] = '0;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (sel_s[j] == SEL_W'(i) && !space_s[j]) begin
          ready_s[i] = 1'b0;
        end else begin
          ready_s[i] = ready_s[i];
        end
      end
    end
    fire_s = bus.in_valid & ready_s;
    // A select value >= NUM_IN matches no input, so that output never pushes.
    for (int j = 0; j < NUM_OUT; j++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel_s[j] == SEL_W'(i)) begin
          push_s[j]      = fire_s[i];
          push_data_s[j] = bus.in_data[i*WIDTH +: WIDTH];
        end else begin
          push_s[j]      = push_s[j];
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (push_s[j]) begin
        mem_d[j][wr_ptr_q[j]] = push_data_s[j];
        wr_ptr_d[j]           = wr_ptr_q[j] + PTR_W'(1);
      end else begin
        wr_ptr_d[j]           = wr_ptr_q[j];
      end
      if (pop_s[j]) begin
        rd_ptr_d[j] = rd_ptr_q[j] + PTR_W'(1);
      end else begin
        rd_ptr_d[j] = rd_ptr_q[j];
      end
      case ({push_s[j], pop_s[j]})
        2'b10:   level_d[j] = level_q[j] + LVL_W'(1);
        2'b01:   level_d[j] = level_q[j] - LVL_W'(1);
        default: level_d[j] = level_q[j];
      endcase
    end
  end

  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        level_q[j]  <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[j][d] <= '0;
        end
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Empty FIFOs drive GND on their data slice rather than a stale entry.
  always_comb begin
    bus.out_data  = '0;
    bus.out_level = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      bus.out_level[j*LVL_W +: LVL_W] = level_q[j];
      if (valid_s[j]) begin
        bus.out_data[j*WIDTH +: WIDTH] = mem_q[j][rd_ptr_q[j]];
      end else begin
        bus.out_data[j*WIDTH +: WIDTH] = '0;
      end
    end
  end

  assign bus.out_valid = valid_s;
  assign bus.in_ready  = ready_s;

endmodule

// File: tb/tb_pe_elastic_switch_matrix.sv
// Scoreboarded bench for pe_elastic_switch_matrix: directed stimulus pushes expected
// words per output; a negedge monitor pops and compares on every output transfer.
module tb_pe_elastic_switch_matrix;
  localparam int WIDTH   = 32;
  localparam int NUM_IN  = 9;
  localparam int NUM_OUT = 7;
  localparam int DEPTH   = 2;
  localparam int SEL_W   = 4;
  localparam int LVL_W   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_OUT*SEL_W-1:0] cfg;

  pe_elastic_switch_matrix_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH)) bus();

  pe_elastic_switch_matrix #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH)) dut (
    .UserCLK    (clk),
    .RESET_N    (rst_n),
    .ConfigBits (cfg),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q [NUM_OUT][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [LVL_W-1:0] lvl(input int j);
    return bus.out_level[j*LVL_W +: LVL_W];
  endfunction

  function automatic logic [WIDTH-1:0] odata(input int j);
    return bus.out_data[j*WIDTH +: WIDTH];
  endfunction

  // Monitor: every transfer on an output must match the next expected word.
  always @(negedge clk) begin
    for (int j = 0; j < NUM_OUT; j++) begin
      if (bus.out_valid[j] && bus.out_ready[j]) begin
        if (exp_q[j].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out%0d_unexpected: got 0x%0h expected no word", j, odata(j));
        end else begin
          check($sformatf("out%0d_data", j), 64'(odata(j)), 64'(exp_q[j].pop_front()));
        end
      end else if (!bus.out_valid[j]) begin
        check($sformatf("out%0d_gnd", j), 64'(odata(j)), 64'd0);
      end
    end
  end

  // One-cycle offer on channel ch; fan marks the outputs expected to receive it.
  task automatic send(input int ch, input logic [WIDTH-1:0] d, input bit exp_rdy,
                      input logic [NUM_OUT-1:0] fan);
    bus.in_data[ch*WIDTH +: WIDTH] = d;
    bus.in_valid[ch] = 1'b1;
    @(negedge clk);
    check($sformatf("in_ready%0d", ch), 64'(bus.in_ready[ch]), 64'(exp_rdy));
    if (exp_rdy) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (fan[j]) exp_q[j].push_back(d);
      end
    end
    @(posedge clk); #1;
    bus.in_valid[ch] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = '0;
    // sel0=3, sel1=sel2=5, sel3..sel6=15 (disconnected); nothing selects 7
    cfg = {4'hF, 4'hF, 4'hF, 4'hF, 4'h5, 4'h5, 4'h3};

    // 1 reset with all inputs valid
    bus.in_valid = '1;
    idle(2);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data_nz", 64'(bus.out_data != '0), 64'd0);
    check("rst_out_level", 64'(bus.out_level), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h1FF);
    bus.in_valid = '0;
    rst_n = 1'b1;
    idle(1);

    // 2 pass-through in3 -> out0, one word per cycle
    bus.out_ready[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      send(3, WIDTH'(k), 1'b1, 7'b0000001);
      check("pt_valid", 64'(bus.out_valid[0]), 64'd1);
      check("pt_latency", 64'(odata(0)), 64'(k));
    end
    idle(1);
    check("pt_drained", 64'(bus.out_valid[0]), 64'd0);

    // 3 fork in5 -> out1, out2 with out2 stalled
    bus.out_ready[0] = 1'b0;
    bus.out_ready[1] = 1'b1;
    bus.out_ready[2] = 1'b0;
    send(5, 32'hA1, 1'b1, 7'b0000110);
    send(5, 32'hA2, 1'b1, 7'b0000110);
    send(5, 32'hA3, 1'b0, 7'b0000110);
    check("fork_lvl2", 64'(lvl(2)), 64'd2);
    check("fork_lvl1", 64'(lvl(1)), 64'd0);
    bus.out_ready[2] = 1'b1;
    idle(2);
    check("fork_lvl2_drained", 64'(lvl(2)), 64'd0);

    // 4 backpressure and full boundary on out0
    bus.out_ready = '0;
    send(3, 32'hB1, 1'b1, 7'b0000001);
    check("bp_lvl_1", 64'(lvl(0)), 64'd1);
    send(3, 32'hB2, 1'b1, 7'b0000001);
    check("bp_lvl_2", 64'(lvl(0)), 64'd2);
    send(3, 32'hB3, 1'b0, 7'b0000001);
    check("bp_lvl_full", 64'(lvl(0)), 64'd2);
    bus.out_ready[0] = 1'b1;
    send(3, 32'hB4, 1'b0, 7'b0000001);
    check("bp_pop_at_full", 64'(lvl(0)), 64'd1);
    send(3, 32'hB5, 1'b1, 7'b0000001);
    check("bp_push_pop_lvl1", 64'(lvl(0)), 64'd1);
    idle(1);
    check("bp_empty", 64'(lvl(0)), 64'd0);

    // 5 unselected inputs sink, disconnected output stays silent
    bus.out_ready = '1;
    send(7, 32'hC7, 1'b1, 7'b0000000);
    send(0, 32'hC0, 1'b1, 7'b0000000);
    idle(1);
    check("sink_no_valid", 64'(bus.out_valid), 64'd0);
    check("disc_valid4", 64'(bus.out_valid[4]), 64'd0);
    check("disc_data4", 64'(odata(4)), 64'd0);

    // 6 asynchronous reset with full FIFOs
    bus.out_ready = '0;
    send(3, 32'hD1, 1'b1, 7'b0000001);
    send(5, 32'hD2, 1'b1, 7'b0000110);
    send(3, 32'hD3, 1'b1, 7'b0000001);
    send(5, 32'hD4, 1'b1, 7'b0000110);
    check("ar_lvl0", 64'(lvl(0)), 64'd2);
    check("ar_lvl2", 64'(lvl(2)), 64'd2);
    check("ar_in_ready5", 64'(bus.in_ready[5]), 64'd0);
    #2;
    rst_n = 1'b0;
    for (int j = 0; j < NUM_OUT; j++) exp_q[j].delete();
    #1;
    check("ar_out_valid", 64'(bus.out_valid), 64'd0);
    check("ar_out_level", 64'(bus.out_level), 64'd0);
    check("ar_out_data_nz", 64'(bus.out_data != '0), 64'd0);
    check("ar_in_ready", 64'(bus.in_ready), 64'h1FF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready[0] = 1'b1;
    send(3, 32'hE1, 1'b1, 7'b0000001);
    check("ar_restart_lvl", 64'(lvl(0)), 64'd1);
    send(3, 32'hE2, 1'b1, 7'b0000001);
    send(3, 32'hE3, 1'b1, 7'b0000001);
    bus.out_ready = '1;
    send(5, 32'hE5, 1'b1, 7'b0000110);

    // drain, bounded
    for (int t = 0; t < 20; t++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      idle(1);
    end
    idle(1);
    for (int j = 0; j < NUM_OUT; j++) begin
      check($sformatf("final_q%0d_empty", j), 64'(exp_q[j].size()), 64'd0);
    end
    check("final_out_valid", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
